iic_cfg_sequencer: RTL and testbench

//  Table-driven scheduler for the board's I2C configuration writes (CH7301 DVI encoder, AD9980 ADC).

---
 rtl/iic_cfg_pkg.sv | 11 +
 rtl/iic_cfg_sequencer_if.sv | 12 +
 rtl/iic_cfg_sequencer.sv | 148 ++++++++++++++
 tb/tb_iic_cfg_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/iic_cfg_pkg.sv
// iic_cfg_pkg: sequencer state encoding, config ROM entry layout and board I2C device addresses
package iic_cfg_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_WAIT, S_GAP, S_DONE, S_ERROR
  } state_t;
  localparam int DEV_MSB = 23;
  localparam int REG_MSB = 15;
  localparam int DAT_MSB = 7;
  localparam logic [7:0] CH7301_ADDR = 8'hEC;
  localparam logic [7:0] AD9980_ADDR = 8'h98;
endpackage

// File: rtl/iic_cfg_sequencer_if.sv
// iic_cfg_sequencer_if: req/done handshake between the config sequencer and the I2C write engine
interface iic_cfg_sequencer_if;
  logic       Wr_req;
  logic [7:0] Wr_dev;
  logic [7:0] Wr_reg;
  logic [7:0] Wr_data;
  logic       Wr_busy;
  logic       Wr_done;
  logic       Wr_nack;
  modport master (output Wr_req, Wr_dev, Wr_reg, Wr_data, input Wr_busy, Wr_done, Wr_nack);
  modport slave  (input Wr_req, Wr_dev, Wr_reg, Wr_data, output Wr_busy, Wr_done, Wr_nack);
endinterface

// File: rtl/iic_cfg_sequencer.sv
// iic_cfg_sequencer: walks the config ROM and issues each entry to the I2C write engine with retry and gap
module iic_cfg_sequencer
  import iic_cfg_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int NUM_ENTRIES = 16,
  parameter int GAP_CYCLES  = 3000,
  parameter int MAX_RETRY   = 3,
  parameter int AUTO_START  = 1
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  Start,
  output logic [ADDR_W-1:0]     Tbl_addr,
  input  logic [23:0]           Tbl_data,
  iic_cfg_sequencer_if.master   w,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic [ADDR_W-1:0]     Err_index
);
  localparam int IW = ADDR_W + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  state_t            st_q, st_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [2:0]        retry_q, retry_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              pend_q, pend_d;
  logic              req_q, req_d;
  logic [7:0]        dev_q, dev_d, reg_q, reg_d, dat_q, dat_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [ADDR_W-1:0] eidx_q, eidx_d;
  logic              go, fin;
  assign Tbl_addr  = idx_q[ADDR_W-1:0];
  assign w.Wr_req  = req_q;
  assign w.Wr_dev  = dev_q;
  assign w.Wr_reg  = reg_q;
  assign w.Wr_data = dat_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Error     = err_q;
  assign Err_index = eidx_q;
  // next-state: a done seen in ISSUE or WAIT resolves the transaction (ack, retry or abort)
  always_comb begin
    st_d    = st_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    gap_d   = gap_q;
    pend_d  = 1'b0;
    req_d   = req_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    dat_d   = dat_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    eidx_d  = eidx_q;
    go      = (Start | pend_q) & ~w.Wr_busy;
    fin     = w.Wr_done & (st_q == S_ISSUE | st_q == S_WAIT);
    case (st_q)
      S_IDLE: begin
        pend_d = (Start | pend_q) & w.Wr_busy;
        if (go) begin
          st_d    = S_FETCH;
          idx_d   = '0;
          retry_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_FETCH: st_d = S_LATCH;
      S_LATCH: begin
        dev_d = Tbl_data[DEV_MSB -: 8] & 8'hFE;
        reg_d = Tbl_data[REG_MSB -: 8];
        dat_d = Tbl_data[DAT_MSB -: 8];
        req_d = 1'b1;
        st_d  = S_ISSUE;
      end
      S_ISSUE: if (w.Wr_busy) begin
        req_d = 1'b0;
        st_d  = S_WAIT;
      end
      S_WAIT: ;
      S_GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q == '0) st_d = idx_q == IW'(NUM_ENTRIES) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        st_d   = S_IDLE;
      end
      S_ERROR: begin
        err_d  = 1'b1;
        eidx_d = idx_q[ADDR_W-1:0];
        busy_d = 1'b0;
        st_d   = S_IDLE;
      end
    endcase
    if (fin) begin
      req_d = 1'b0;
      gap_d = GW'(GAP_CYCLES - 1);
      if (!w.Wr_nack) begin
        st_d    = S_GAP;
        retry_d = '0;
        idx_d   = idx_q + IW'(1);
      end else if (retry_q < 3'(MAX_RETRY)) begin
        st_d    = S_GAP;
        retry_d = retry_q + 3'd1;
      end else begin
        st_d = S_ERROR;
      end
    end
  end
  // state and registered outputs; reset aborts any run and arms the auto-start
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      st_q    <= S_IDLE;
      idx_q   <= '0;
      retry_q <= '0;
      gap_q   <= '0;
      pend_q  <= AUTO_START != 0;
      req_q   <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      dat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      eidx_q  <= '0;
    end else begin
      st_q    <= st_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      eidx_q  <= eidx_d;
    end
  end
endmodule

// File: tb/tb_iic_cfg_sequencer.sv
// tb_iic_cfg_sequencer: scoreboard bench with a behavioural ROM and write engine
module tb_iic_cfg_sequencer;
  import iic_cfg_pkg::*;
  logic clk = 1'b0;
  logic Reset = 1'b1;
  logic Start = 1'b0;
  logic [4:0] Tbl_addr;
  logic [23:0] Tbl_data;
  logic Busy, Done, Error;
  logic [4:0] Err_index;
  logic force_busy = 1'b0;
  int total = 0;
  int bad = 0;
  int issues = 0;
  logic [23:0] rom [32];
  logic [23:0] ex [4];
  logic [23:0] exp_q [$];
  logic nq [$];
  iic_cfg_sequencer_if w ();
  iic_cfg_sequencer #(.ADDR_W(5), .NUM_ENTRIES(4), .GAP_CYCLES(10), .MAX_RETRY(2), .AUTO_START(1)) dut (
    .clk(clk), .Reset(Reset), .Start(Start), .Tbl_addr(Tbl_addr), .Tbl_data(Tbl_data),
    .w(w), .Busy(Busy), .Done(Done), .Error(Error), .Err_index(Err_index)
  );
  always #5 clk = ~clk;
  always @(posedge clk) Tbl_data <= rom[Tbl_addr];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic push(input int i);
    exp_q.push_back(ex[i]);
  endtask
  task automatic pulse_start();
    @(negedge clk) Start = 1'b1;
    @(negedge clk) Start = 1'b0;
  endtask
  task automatic wait_busy(input logic v, input int lim, input string n);
    int k = 0;
    while (Busy !== v && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(n, Busy, v);
  endtask
  // write engine: accepts a request, stays busy 3 cycles, then pulses done with the next scheduled nack
  initial begin
    int cnt;
    logic eb;
    cnt = 0;
    eb = 1'b0;
    w.Wr_busy = 1'b0;
    w.Wr_done = 1'b0;
    w.Wr_nack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      w.Wr_done = 1'b0;
      if (Reset) begin
        eb = 1'b0;
        cnt = 0;
      end else if (eb) begin
        cnt--;
        if (cnt == 0) begin
          eb = 1'b0;
          w.Wr_done = 1'b1;
          w.Wr_nack = nq.size() > 0 ? nq.pop_front() : 1'b0;
        end
      end else if (w.Wr_req && !force_busy) begin
        eb = 1'b1;
        cnt = 3;
      end
      w.Wr_busy = eb | force_busy;
    end
  end
  // monitor: every Wr_req rise is popped against the scoreboard and timed against the previous done
  initial begin
    int mcyc, done_cyc;
    logic req_prev, gap_ok;
    mcyc = 0;
    done_cyc = 0;
    req_prev = 1'b0;
    gap_ok = 1'b0;
    forever begin
      @(negedge clk);
      mcyc++;
      if (Reset || !Busy) gap_ok = 1'b0;
      if (!Reset && w.Wr_req && !req_prev) begin
        issues++;
        if (gap_ok) chk("gap", mcyc - done_cyc, 13);
        if (exp_q.size() == 0) chk("unexpected_req", {8'h0, w.Wr_dev, w.Wr_reg, w.Wr_data}, 32'hFFFFFFFF);
        else chk("entry", {w.Wr_dev, w.Wr_reg, w.Wr_data}, exp_q.pop_front());
      end
      if (w.Wr_done) begin
        done_cyc = mcyc;
        gap_ok = 1'b1;
      end
      req_prev = w.Wr_req;
    end
  end
  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 24'h0;
    rom[0] = {CH7301_ADDR, 8'h49, 8'hC0};
    rom[1] = {AD9980_ADDR, 8'h01, 8'h23};
    rom[2] = 24'hED_21_09;
    rom[3] = 24'h99_7F_A5;
    ex[0] = 24'hEC_49_C0;
    ex[1] = 24'h98_01_23;
    ex[2] = 24'hEC_21_09;
    ex[3] = 24'h98_7F_A5;
    repeat (3) @(negedge clk);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_error", Error, 0);
    chk("rst_req", w.Wr_req, 0);
    chk("rst_addr", Tbl_addr, 0);
    chk("rst_eidx", Err_index, 0);
    for (int i = 0; i < 4; i++) push(i);
    issues = 0;
    Reset = 1'b0;
    wait_busy(1, 5, "t1_autostart");
    wait_busy(0, 1000, "t1_end");
    chk("t1_done", Done, 1);
    chk("t1_error", Error, 0);
    chk("t1_issues", issues, 4);
    chk("t1_sb_empty", exp_q.size(), 0);
    push(0); push(1); push(2); push(2); push(3);
    nq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    issues = 0;
    pulse_start();
    wait_busy(1, 5, "t2_start");
    chk("t2_done_cleared", Done, 0);
    wait_busy(0, 1000, "t2_end");
    chk("t2_done", Done, 1);
    chk("t2_error", Error, 0);
    chk("t2_issues", issues, 5);
    chk("t2_sb_empty", exp_q.size(), 0);
    push(0); push(1); push(1); push(1);
    nq = '{1'b0, 1'b1, 1'b1, 1'b1};
    issues = 0;
    pulse_start();
    wait_busy(1, 5, "t3_start");
    wait_busy(0, 1000, "t3_end");
    chk("t3_error", Error, 1);
    chk("t3_done", Done, 0);
    chk("t3_eidx", Err_index, 1);
    chk("t3_issues", issues, 4);
    chk("t3_sb_empty", exp_q.size(), 0);
    for (int i = 0; i < 4; i++) push(i);
    issues = 0;
    @(negedge clk) force_busy = 1'b1;
    repeat (2) @(negedge clk);
    pulse_start();
    repeat (5) @(negedge clk);
    chk("t6_pend_hold", Busy, 0);
    force_busy = 1'b0;
    wait_busy(1, 10, "t6_pend_go");
    chk("t6_error_cleared", Error, 0);
    for (int k = 0; k < 500 && issues < 2; k++) @(negedge clk);
    pulse_start();
    repeat (4) @(negedge clk);
    pulse_start();
    wait_busy(0, 1000, "t6_end");
    chk("t6_done", Done, 1);
    chk("t6_issues", issues, 4);
    repeat (20) @(negedge clk);
    chk("t6_no_queue", Busy, 0);
    push(0); push(1); push(2);
    issues = 0;
    pulse_start();
    for (int k = 0; k < 500 && issues < 3; k++) @(negedge clk);
    chk("t5_reached_e2", issues, 3);
    @(posedge clk);
    #3 Reset = 1'b1;
    #1;
    chk("t5_busy", Busy, 0);
    chk("t5_req", w.Wr_req, 0);
    chk("t5_dev", w.Wr_dev, 0);
    chk("t5_addr", Tbl_addr, 0);
    chk("t5_done", Done, 0);
    exp_q.delete();
    nq.delete();
    for (int i = 0; i < 4; i++) push(i);
    issues = 0;
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    wait_busy(1, 5, "t5_rerun");
    wait_busy(0, 1000, "t5_end");
    chk("t5_done_end", Done, 1);
    chk("t5_error_end", Error, 0);
    chk("t5_issues", issues, 4);
    chk("t5_sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
